// File: rtl/rst_ctrl_if.sv
// rst_ctrl_if: request inputs and reset/status outputs of the reset sequencer (sw_rst_req, wdt_en, wdt_kick in; periph_rst, core_rst, ready, rst_cause out)
interface rst_ctrl_if;
  logic       sw_rst_req;
  logic       wdt_en;
  logic       wdt_kick;
  logic       periph_rst;
  logic       core_rst;
  logic       ready;
  logic [1:0] rst_cause;
  modport master (output sw_rst_req, wdt_en, wdt_kick, input periph_rst, core_rst, ready, rst_cause);
  modport slave (input sw_rst_req, wdt_en, wdt_kick, output periph_rst, core_rst, ready, rst_cause);
endinterface

// File: rtl/rst_ctrl.sv
// rst_ctrl: synchronises rst_n, stretches and staggers periph/core reset, re-enters reset on sw request or watchdog (ports: clk, rst_n, bus = rst_ctrl_if.slave)
module rst_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int WDT_WIDTH      = 16,
  parameter int WDT_TIMEOUT    = 1000
) (
  input logic       clk,
  input logic       rst_n,
  rst_ctrl_if.slave bus
);
  localparam int CW = $clog2((HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES) + 1;
  typedef enum logic [1:0] {HOLD, STAGGER, RUN} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WDT_WIDTH-1:0]   wdt_q, wdt_d;
  logic                   periph_rst_q, periph_rst_d;
  logic                   core_rst_q, core_rst_d;
  logic                   ready_q, ready_d;
  logic [1:0]             cause_q, cause_d;
  logic                   sync_rst_n, in_run, wdt_fire, trig;
  assign sync_rst_n = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], 1'b1};
    in_run       = state_q == RUN;
    wdt_fire     = in_run && bus.wdt_en && !bus.wdt_kick && wdt_q == WDT_WIDTH'(WDT_TIMEOUT - 1);
    trig         = in_run && (bus.sw_rst_req || wdt_fire);
    wdt_d        = (!in_run || !bus.wdt_en || bus.wdt_kick || trig) ? '0 : wdt_q + 1'b1;
    state_d      = state_q;
    cnt_d        = cnt_q;
    periph_rst_d = periph_rst_q;
    core_rst_d   = core_rst_q;
    ready_d      = ready_q;
    cause_d      = cause_q;
    case (state_q)
      HOLD: if (sync_rst_n) begin
        cnt_d = (cnt_q == CW'(HOLD_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          periph_rst_d = 1'b0;
          state_d      = STAGGER;
        end
      end
      STAGGER: begin
        cnt_d = (cnt_q == CW'(STAGGER_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
        if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
          core_rst_d = 1'b0;
          ready_d    = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: if (trig) begin
        periph_rst_d = 1'b1;
        core_rst_d   = 1'b1;
        ready_d      = 1'b0;
        cnt_d        = '0;
        cause_d      = bus.sw_rst_req ? 2'b01 : 2'b10;
        state_d      = HOLD;
      end
      default: state_d = HOLD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HOLD;
      sync_q       <= '0;
      cnt_q        <= '0;
      wdt_q        <= '0;
      periph_rst_q <= 1'b1;
      core_rst_q   <= 1'b1;
      ready_q      <= 1'b0;
      cause_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      wdt_q        <= wdt_d;
      periph_rst_q <= periph_rst_d;
      core_rst_q   <= core_rst_d;
      ready_q      <= ready_d;
      cause_q      <= cause_d;
    end
  end
  assign bus.periph_rst = periph_rst_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.ready      = ready_q;
  assign bus.rst_cause  = cause_q;
endmodule

// File: tb/tb_rst_ctrl.sv
// tb_rst_ctrl: directed checks of external, software and watchdog reset sequencing
module tb_rst_ctrl;
  logic clk;
  logic rst_n;
  int   tests;
  int   failed;
  rst_ctrl_if bus ();
  rst_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #10 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic seq(input string t, input int pe, input int ce, input int sw_on, input int sw_off);
    for (int i = 1; i <= ce; i++) begin
      tick(1);
      check({t, "_inv"}, 32'(bus.core_rst | !bus.periph_rst), 1);
      check({t, "_periph"}, 32'(bus.periph_rst), 32'(i < pe));
      check({t, "_core"}, 32'(bus.core_rst), 32'(i < ce));
      check({t, "_ready"}, 32'(bus.ready), 32'(i >= ce));
      if (i == sw_on) bus.sw_rst_req = 1'b1;
      if (i == sw_off) bus.sw_rst_req = 1'b0;
    end
  endtask
  task automatic asserted(input string t, input logic [1:0] cause);
    check({t, "_periph_on"}, 32'(bus.periph_rst), 1);
    check({t, "_core_on"}, 32'(bus.core_rst), 1);
    check({t, "_ready_off"}, 32'(bus.ready), 0);
    check({t, "_cause"}, 32'(bus.rst_cause), 32'(cause));
  endtask
  task automatic sw_pulse();
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
  endtask
  task automatic pulse_rst_n(input string t);
    #4 rst_n = 1'b0;
    #1 asserted(t, 2'b00);
    #3 rst_n = 1'b1;
  endtask
  initial begin
    tests = 0;
    failed = 0;
    rst_n = 1'b0;
    bus.sw_rst_req = 1'b0;
    bus.wdt_en = 1'b0;
    bus.wdt_kick = 1'b0;
    #100 asserted("por", 2'b00);
    #100 rst_n = 1'b1;
    seq("ext", 18, 22, -1, -1);
    check("ext_cause", 32'(bus.rst_cause), 0);
    sw_pulse();
    asserted("sw", 2'b01);
    seq("sw", 16, 20, -1, -1);
    bus.wdt_en = 1'b1;
    tick(999);
    check("wdt_pre", 32'(bus.ready), 1);
    tick(1);
    asserted("wdt", 2'b10);
    seq("wdt", 16, 20, -1, -1);
    repeat (10) begin
      tick(998);
      bus.wdt_kick = 1'b1;
      tick(1);
      bus.wdt_kick = 1'b0;
      check("kick_ready", 32'(bus.ready), 1);
    end
    tick(999);
    check("exp_armed", 32'(bus.ready), 1);
    bus.wdt_kick = 1'b1;
    tick(1);
    bus.wdt_kick = 1'b0;
    check("kick_exp_ready", 32'(bus.ready), 1);
    check("kick_exp_periph", 32'(bus.periph_rst), 0);
    tick(999);
    sw_pulse();
    asserted("sw_exp", 2'b01);
    seq("sw_exp", 16, 20, -1, -1);
    tick(3);
    check("sw_exp_single", 32'(bus.ready), 1);
    bus.wdt_en = 1'b0;
    sw_pulse();
    tick(18);
    check("stg_periph", 32'(bus.periph_rst), 0);
    check("stg_core", 32'(bus.core_rst), 1);
    pulse_rst_n("stg_rst");
    seq("ext_stg", 18, 22, -1, -1);
    sw_pulse();
    seq("sw2", 16, 20, -1, -1);
    check("sw2_cause", 32'(bus.rst_cause), 1);
    pulse_rst_n("run_rst");
    seq("ext_run", 18, 22, 5, 8);
    tick(3);
    check("hold_sw_ready", 32'(bus.ready), 1);
    check("hold_sw_cause", 32'(bus.rst_cause), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
